// File: rtl/tmp_code_acc.sv
// Temperature code accumulator: integrates pump source/sink events over
// averaged measurement windows and emits an offset-binary code with a valid strobe.
module tmp_code_acc #(
  parameter int CODE_W   = 12,
  parameter int WIN_LOG2 = 8,
  parameter int AVG_LOG2 = 2,
  parameter int SETTLE   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              setup_bias,
  input  logic              src_evt,
  input  logic              snk_evt,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              busy,
  output logic              ovf
);

  localparam int ACC_W     = CODE_W + AVG_LOG2;
  localparam int ACC_CYC_W = WIN_LOG2 + AVG_LOG2;
  localparam int SET_W     = $clog2(SETTLE + 1);
  localparam int CNT_W     = (ACC_CYC_W > SET_W) ? ACC_CYC_W : SET_W;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] ACCUM_LAST  = CNT_W'((2 ** ACC_CYC_W) - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);

  localparam logic signed [ACC_W:0] CODE_MID = (ACC_W+1)'(2 ** (CODE_W - 1));
  localparam logic signed [ACC_W:0] CODE_TOP = (ACC_W+1)'((2 ** CODE_W) - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM,
    ST_DONE
  } state_t;

  state_t                   state_reg;
  logic [CNT_W-1:0]         cnt_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic                     ovf_reg;

  logic signed [ACC_W-1:0]  acc_next;
  logic                     ovf_next;
  logic signed [ACC_W-1:0]  avg;
  logic signed [ACC_W:0]    code_wide;
  logic [CODE_W-1:0]        code_next;
  logic                     go;

  assign go = en && !setup_bias;

  // Saturating step; simultaneous source and sink events cancel.
  always_comb begin
    acc_next = acc_reg;
    ovf_next = ovf_reg;
    if (src_evt && !snk_evt) begin
      if (acc_reg == ACC_MAX) ovf_next = 1'b1;
      else                    acc_next = acc_reg + ACC_ONE;
    end else if (snk_evt && !src_evt) begin
      if (acc_reg == ACC_MIN) ovf_next = 1'b1;
      else                    acc_next = acc_reg - ACC_ONE;
    end
  end

  // Result uses acc_next so an event in the final accumulation cycle counts.
  always_comb begin
    avg       = acc_next >>> AVG_LOG2;
    code_wide = $signed({avg[ACC_W-1], avg}) + CODE_MID;
    if (code_wide[ACC_W])           code_next = '0;
    else if (code_wide > CODE_TOP)  code_next = '1;
    else                            code_next = code_wide[CODE_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      ovf_reg   <= 1'b0;
      code      <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          cnt_reg <= '0;
          acc_reg <= '0;
          ovf_reg <= 1'b0;
          if (go) begin
            state_reg <= ST_SETTLE;
            busy      <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (!go) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end else if (cnt_reg == SETTLE_LAST) begin
            state_reg <= ST_ACCUM;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        ST_ACCUM: begin
          if (!go) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end else begin
            acc_reg <= acc_next;
            ovf_reg <= ovf_next;
            if (cnt_reg == ACCUM_LAST) begin
              state_reg <= ST_DONE;
              busy      <= 1'b0;
              valid     <= 1'b1;
              code      <= code_next;
              ovf       <= ovf_next;
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end
        end
        ST_DONE: begin
          cnt_reg <= '0;
          acc_reg <= '0;
          ovf_reg <= 1'b0;
          if (go) begin
            state_reg <= ST_SETTLE;
            busy      <= 1'b1;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmp_code_acc.sv
// Directed bench for tmp_code_acc: default instance plus a narrow saturating instance.
module tb_tmp_code_acc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        en_s = 1'b0;
  logic        setup_bias = 1'b0;
  logic        src_evt = 1'b0;
  logic        snk_evt = 1'b0;

  logic [11:0] code;
  logic        valid, busy, ovf;
  logic [3:0]  code_s;
  logic        valid_s, busy_s, ovf_s;

  int n_cmp  = 0;
  int n_fail = 0;

  int   vc, nv;
  logic b1, bv, ba;

  always #5 clk = ~clk;

  tmp_code_acc u_dut (
    .clk(clk), .reset(reset), .en(en), .setup_bias(setup_bias),
    .src_evt(src_evt), .snk_evt(snk_evt),
    .code(code), .valid(valid), .busy(busy), .ovf(ovf)
  );

  tmp_code_acc #(.CODE_W(4), .WIN_LOG2(8), .AVG_LOG2(0), .SETTLE(16)) u_small (
    .clk(clk), .reset(reset), .en(en_s), .setup_bias(setup_bias),
    .src_evt(src_evt), .snk_evt(snk_evt),
    .code(code_s), .valid(valid_s), .busy(busy_s), .ovf(ovf_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_en(input bit sel, input logic v);
    if (sel) en_s = v;
    else     en = v;
  endtask

  // mode 0: src every cycle; 1: snk on odd accum cycles; 2: src+snk on odd
  // accum cycles; 3: src during settle only; 4: no events.
  task automatic drive_evt(input int mode, input int c);
    int k;
    k = c - 16;
    src_evt = 1'b0;
    snk_evt = 1'b0;
    case (mode)
      0: src_evt = 1'b1;
      1: if (k >= 1 && k <= 1024 && (k % 2) == 1) snk_evt = 1'b1;
      2: if (k >= 1 && k <= 1024 && (k % 2) == 1) begin snk_evt = 1'b1; src_evt = 1'b1; end
      3: if (c >= 1 && c <= 16) src_evt = 1'b1;
      default: ;
    endcase
  endtask

  // Starts a conversion (enabling edge = edge 0) and watches 1100 cycles.
  task automatic run_conv(input bit sel, input int mode, input int abort_k, input bit abort_bias,
                          output int vcyc, output int nvalid,
                          output logic busy_c1, output logic busy_v, output logic busy_ab);
    logic v, b;
    vcyc = 0; nvalid = 0; busy_c1 = 1'b0; busy_v = 1'b1; busy_ab = 1'b1;
    @(negedge clk);
    drive_en(sel, 1'b1);
    drive_evt(mode, 0);
    for (int c = 1; c <= 1100; c++) begin
      @(posedge clk);
      @(negedge clk);
      v = sel ? valid_s : valid;
      b = sel ? busy_s : busy;
      if (c == 1) busy_c1 = b;
      if (v) begin
        nvalid++;
        if (vcyc == 0) begin
          vcyc   = c;
          busy_v = b;
        end
        drive_en(sel, 1'b0);
      end
      if (abort_k > 0 && c == 16 + abort_k) begin
        if (abort_bias) setup_bias = 1'b1;
        else            drive_en(sel, 1'b0);
      end
      if (abort_k > 0 && c == 16 + abort_k + 1) begin
        busy_ab    = b;
        setup_bias = 1'b0;
        drive_en(sel, 1'b0);
      end
      drive_evt(mode, c);
    end
    src_evt = 1'b0;
    snk_evt = 1'b0;
  endtask

  initial begin
    // Power-on reset
    #1;
    check("rst_code",  32'(code),  32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_ovf",   32'(ovf),   32'd0);
    check("rst_code_s", 32'(code_s), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Source every cycle: 1024 counts -> avg 256 -> 0x900
    run_conv(1'b0, 0, 0, 1'b0, vc, nv, b1, bv, ba);
    check("src_all_vcycle", 32'(vc), 32'd1041);
    check("src_all_nvalid", 32'(nv), 32'd1);
    check("src_all_code",   32'(code), 32'd2304);
    check("src_all_ovf",    32'(ovf), 32'd0);
    check("src_all_busy1",  32'(b1), 32'd1);
    check("src_all_busyv",  32'(bv), 32'd0);

    // Asynchronous reset in the middle of ACCUM
    @(negedge clk);
    en = 1'b1; src_evt = 1'b1;
    repeat (100) @(posedge clk);
    #2;
    check("mid_busy_pre", 32'(busy), 32'd1);
    check("mid_code_pre", 32'(code), 32'd2304);
    reset = 1'b1;
    #1;
    check("mid_rst_code",  32'(code),  32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_busy",  32'(busy),  32'd0);
    check("mid_rst_ovf",   32'(ovf),   32'd0);
    @(negedge clk);
    en = 1'b0; src_evt = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_code", 32'(code), 32'd0);
    run_conv(1'b0, 0, 0, 1'b0, vc, nv, b1, bv, ba);
    check("post_rst_vcycle", 32'(vc), 32'd1041);
    check("post_rst_nvalid", 32'(nv), 32'd1);
    check("post_rst_code",   32'(code), 32'd2304);

    // Settle-phase events are dropped
    run_conv(1'b0, 3, 0, 1'b0, vc, nv, b1, bv, ba);
    check("settle_only_code", 32'(code), 32'd2048);
    check("settle_only_nv",   32'(nv), 32'd1);

    // 512 sink events -> avg -128 -> 0x780
    run_conv(1'b0, 1, 0, 1'b0, vc, nv, b1, bv, ba);
    check("snk_half_code", 32'(code), 32'd1920);
    check("snk_half_ovf",  32'(ovf), 32'd0);

    // Simultaneous source and sink cancel
    run_conv(1'b0, 2, 0, 1'b0, vc, nv, b1, bv, ba);
    check("both_half_code", 32'(code), 32'd2048);

    // Abort by dropping en, then by pulsing setup_bias
    run_conv(1'b0, 0, 0, 1'b0, vc, nv, b1, bv, ba);
    check("pre_abort_code", 32'(code), 32'd2304);
    run_conv(1'b0, 4, 500, 1'b0, vc, nv, b1, bv, ba);
    check("abort_en_nvalid", 32'(nv), 32'd0);
    check("abort_en_busy",   32'(ba), 32'd0);
    check("abort_en_code",   32'(code), 32'd2304);
    check("abort_en_ovf",    32'(ovf), 32'd0);
    run_conv(1'b0, 4, 500, 1'b1, vc, nv, b1, bv, ba);
    check("abort_bias_nvalid", 32'(nv), 32'd0);
    check("abort_bias_busy",   32'(ba), 32'd0);
    check("abort_bias_code",   32'(code), 32'd2304);

    // Narrow instance: saturation at +7, then a quiet conversion
    run_conv(1'b1, 0, 0, 1'b0, vc, nv, b1, bv, ba);
    check("sat_vcycle", 32'(vc), 32'd273);
    check("sat_code",   32'(code_s), 32'd15);
    check("sat_ovf",    32'(ovf_s), 32'd1);
    run_conv(1'b1, 4, 0, 1'b0, vc, nv, b1, bv, ba);
    check("quiet_code", 32'(code_s), 32'd8);
    check("quiet_ovf",  32'(ovf_s), 32'd0);
    check("quiet_nv",   32'(nv), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
